// File: rtl/icache_pkg.sv
// icache_pkg: shared types and widths for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic {LOOKUP, MISS} state_e;
  localparam int LINE_W = 64;
  localparam int WORD_W = 32;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with sync write, comb read and bulk valid clear.
module icache_line_array import icache_pkg::*; #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 26
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o
);
  localparam int LINES = 1 << IDX_W;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  // Clear wins over a same-cycle write so an aborted refill never becomes visible.
  always_ff @(posedge clk_i) begin
    if (clear_i) valid_q <= '0;
    else if (we_i) valid_q[wr_idx_i] <= 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped 64-bit-line instruction cache with a LOOKUP/MISS refill FSM.
module instruction_cache import icache_pkg::*; #(
  parameter int cacheLines = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fetchPC,
  input  logic              fetchRequest,
  input  logic              invalidate,
  output logic [WORD_W-1:0] instruction,
  output logic              instructionValid,
  output logic              stall,
  output logic [31:0]       passedPC,
  output logic              instructionRequest,
  input  logic [LINE_W-1:0] cacheData,
  input  logic              receivedInstruction,
  output logic [31:0]       hitCount,
  output logic [31:0]       missCount
);
  localparam int IDX_W = $clog2(cacheLines);
  localparam int TAG_W = 29 - IDX_W;
  state_e            state_q, state_d;
  logic [28:0]       miss_pc_q, miss_pc_d;
  logic              miss_cycle_q, miss_cycle_d;
  logic [31:0]       hit_cnt_q, miss_cnt_q;
  logic              line_valid, hit, accept, miss_start, unused_pc;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  assign unused_pc = ^fetchPC[1:0];
  icache_line_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
    .clk_i      (clk),
    .clear_i    (reset | invalidate),
    .we_i       (accept & ~reset),
    .wr_idx_i   (miss_pc_q[IDX_W-1:0]),
    .wr_tag_i   (miss_pc_q[28 -: TAG_W]),
    .wr_data_i  (cacheData),
    .rd_idx_i   (fetchPC[3 +: IDX_W]),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data)
  );
  assign hit = !reset && state_q == LOOKUP && fetchRequest && !invalidate &&
               line_valid && line_tag == fetchPC[31 -: TAG_W];
  // The first MISS cycle may still see a pulse meant for an earlier request.
  assign accept = state_q == MISS && miss_cycle_q && receivedInstruction && !invalidate;
  assign miss_start = state_q == LOOKUP && fetchRequest && !hit && !invalidate;
  always_comb begin
    state_d      = state_q == LOOKUP ? (miss_start ? MISS : LOOKUP)
                                     : ((invalidate || accept) ? LOOKUP : MISS);
    miss_pc_d    = miss_start ? fetchPC[31:3] : miss_pc_q;
    miss_cycle_d = state_q == MISS;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOOKUP;
      miss_pc_q    <= '0;
      miss_cycle_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      miss_cycle_q <= miss_cycle_d;
      hit_cnt_q    <= hit_cnt_q + {31'b0, hit};
      miss_cnt_q   <= miss_cnt_q + {31'b0, miss_start};
    end
  end
  assign instructionValid   = hit;
  assign instruction        = hit ? (fetchPC[2] ? line_data[31:0] : line_data[63:32]) : '0;
  assign stall              = fetchRequest && !hit;
  assign instructionRequest = !reset && state_q == MISS;
  assign passedPC           = reset ? 32'h0 : {miss_pc_q, 3'b000};
  assign hitCount           = hit_cnt_q;
  assign missCount          = miss_cnt_q;
endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter: cacheLines, 8, number of direct-mapped lines (power of two, >=2); each line holds 64 bits (two instructions).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 Port: fetchPC  input  32  byte address requested by fetch; bits [1:0] ignored.
REQ-005 Port: fetchRequest  input  1  fetch wants the instruction at fetchPC this cycle (level).
REQ-006 Port: invalidate  input  1  clear all valid bits (fence.i/flush).
REQ-007 Port: instruction  output  32  instruction for fetchPC; meaningful only when instructionValid=1, else 0.
REQ-008 Port: instructionValid  output  1  hit this cycle; fetch may advance.
REQ-009 Port: stall  output  1  equals fetchRequest AND NOT instructionValid.
REQ-010 Port: passedPC  output  32  line address to instruction memory, {missPC[31:3],3'b000}.
REQ-011 Port: instructionRequest  output  1  refill request to instruction memory.
REQ-012 Port: cacheData  input  64  refill line; [63:32]=even word (PC[2]=0), [31:0]=odd word (PC[2]=1).
REQ-013 Port: receivedInstruction  input  1  memory asserts while cacheData is driven.
REQ-014 Port: hitCount  output  32  fetch hits counted; wraps modulo 2^32.
REQ-015 Port: missCount  output  32  misses entered; wraps modulo 2^32.

Function
REQ-016 Address split: word select PC[2], index PC[3+log2(cacheLines)-1:3], tag = remaining upper bits.
REQ-017 FSM states: LOOKUP, MISS; no other states.
REQ-018 LOOKUP: hit = fetchRequest AND valid[index] AND tag match; instructionValid and instruction are combinational, zero latency.
REQ-019 LOOKUP with fetchRequest and no hit and invalidate=0: latch missPC<=fetchPC, clear missCycle, increment missCount, go MISS.
REQ-020 MISS: instructionRequest=1, passedPC held constant from latched missPC; instructionValid=0; fetchPC changes ignored.
REQ-021 MISS: receivedInstruction ignored in the first MISS cycle (stale memory pulse); accepted from the second MISS cycle on.
REQ-022 On accept: write cacheData, tag, valid=1 to line[missPC index]; go LOOKUP; instructionRequest=0 from the next cycle.
REQ-023 Return to LOOKUP re-evaluates current fetchPC; miss-to-hit minimum latency 3 cycles after miss detection.
REQ-024 receivedInstruction in LOOKUP (including first cycle after reset) SHALL have no effect.
REQ-025 invalidate (any state): all valid bits cleared at the edge; in MISS, refill aborted, no line written, go LOOKUP; invalidate beats a same-cycle accept.
REQ-026 invalidate in LOOKUP forces instructionValid=0 that cycle.
REQ-027 hitCount increments each cycle instructionValid=1; no counting when fetchRequest=0.
REQ-028 Refill into a valid line overwrites it (no replacement choice).

Reset
REQ-029 reset=1 at an edge: state LOOKUP, all valid bits 0, missPC 0, missCycle 0, hitCount 0, missCount 0; data/tag arrays need not clear.
REQ-030 During and after reset: instruction=0, instructionValid=0, stall=fetchRequest, instructionRequest=0, passedPC=0.
REQ-031 reset mid-MISS aborts refill; no line written; later memory pulse ignored per REQ-024.

Structure
REQ-032 Package icache_pkg holds the state enum (LOOKUP, MISS), line width 64, word width 32.
REQ-033 One sub-module icache_line_array: valid/tag/data storage, synchronous write, combinational read, bulk valid clear.
REQ-034 FSM, counters, address split remain in instruction_cache.

Verification
REQ-035 Reset, fetchPC=0x0, fetchRequest=1, memory holding word0=0x00500113, word1=0x00300193 -> stall, request with passedPC=0x0, later instructionValid with instruction=0x00500113, missCount=1.
REQ-036 Then fetchPC=0x4 -> same-cycle hit, instruction=0x00300193, hitCount increments, no request.
REQ-037 receivedInstruction pulsed in first MISS cycle with cacheData=0xDEADBEEF_DEADBEEF -> ignored; correct line written on later pulse.
REQ-038 fetchPC=0x10 miss, invalidate in MISS -> no write, LOOKUP next cycle; fetchPC=0x0 then misses again.
REQ-039 fetchPC=0x0 cached, fetchPC=0x40 (same index, cacheLines=8) -> miss, refill evicts; fetchPC=0x0 misses again.
REQ-040 reset asserted mid-MISS -> all outputs at reset values next cycle, valid bits clear, counters 0.
